// File: rtl/difftest_step_batcher_if.sv
// Handshake bundle between the commit source and difftest_step_batcher.
//   master : drives in_valid, in_steps, flush_req, simv_result; observes outputs
//   slave  : the batcher; consumes the inputs, drives step, pending, total_steps
interface difftest_step_batcher_if #(
  parameter int STEP_WIDTH = 8,
  parameter int IN_WIDTH   = 4
);
  logic                  in_valid;
  logic [IN_WIDTH-1:0]   in_steps;
  logic                  flush_req;
  logic                  simv_result;
  logic [STEP_WIDTH-1:0] step;
  logic                  pending;
  logic [63:0]           total_steps;

  modport master (
    output in_valid, in_steps, flush_req, simv_result,
    input  step, pending, total_steps
  );

  modport slave (
    input  in_valid, in_steps, flush_req, simv_result,
    output step, pending, total_steps
  );
endinterface

// File: rtl/difftest_step_batcher.sv
// difftest_step_batcher
//   Folds per-cycle commit counts into occasional batched step pulses so the
//   downstream nstep call fires rarely. A batch is flushed when the running
//   count reaches THRESHOLD, when it has sat unflushed for TIMEOUT cycles, or
//   on flush_req. Once simv_result is seen the block goes permanently quiet
//   until reset.
// Ports
//   clock        clock
//   reset        synchronous, active-high
//   bus (slave)  in_valid/in_steps/flush_req/simv_result in,
//                step/pending/total_steps out (all outputs registered)
//
//   state | meaning
//   IDLE  | nothing accumulated (acc == 0)
//   ACCUM | nonzero count held, waiting for threshold/timeout/flush_req
//   HALT  | simulation result seen; inputs ignored, outputs held at rest
module difftest_step_batcher #(
  parameter int STEP_WIDTH = 8,
  parameter int IN_WIDTH   = 4,
  parameter int THRESHOLD  = 64,
  parameter int TIMEOUT    = 16
) (
  input logic                    clock,
  input logic                    reset,
  difftest_step_batcher_if.slave bus
);
  localparam int ACC_W = STEP_WIDTH + 1;
  // One extra bit over acc so acc + in_steps never wraps.
  localparam int SUM_W = STEP_WIDTH + 2;
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  localparam logic [SUM_W-1:0] MAXS      = {2'b00, {STEP_WIDTH{1'b1}}};
  localparam logic [SUM_W-1:0] THRESH    = SUM_W'(THRESHOLD);
  localparam logic [CNT_W-1:0] IDLE_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, ACCUM, HALT} state_t;

  state_t                state;
  logic [ACC_W-1:0]      acc;
  logic [CNT_W-1:0]      idle_cnt;
  logic [STEP_WIDTH-1:0] step_q;
  logic                  pending_q;
  logic [63:0]           total_q;

  logic [SUM_W-1:0]      sum;
  logic [SUM_W-1:0]      emit;
  logic [ACC_W-1:0]      rem;
  logic                  flush;

  always_comb begin
    sum   = {1'b0, acc} + (bus.in_valid ? SUM_W'(bus.in_steps) : '0);
    flush = (sum >= THRESH) ||
            (bus.flush_req && (sum != '0)) ||
            ((acc != '0) && (idle_cnt == IDLE_LAST));
    // A batch larger than one pulse can carry leaves a remainder in acc.
    emit  = (sum > MAXS) ? MAXS : sum;
    rem   = ACC_W'(sum - emit);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      acc       <= '0;
      idle_cnt  <= '0;
      step_q    <= '0;
      pending_q <= 1'b0;
      total_q   <= '0;
    end else if (state == HALT) begin
      step_q <= '0;
    end else if (bus.simv_result) begin
      // Halt takes priority over any flush due this same cycle.
      state     <= HALT;
      acc       <= '0;
      idle_cnt  <= '0;
      step_q    <= '0;
      pending_q <= 1'b0;
    end else if (flush) begin
      step_q    <= emit[STEP_WIDTH-1:0];
      acc       <= rem;
      idle_cnt  <= '0;
      total_q   <= total_q + 64'(emit);
      pending_q <= (rem != '0);
      state     <= (rem != '0) ? ACCUM : IDLE;
    end else begin
      // Without a flush, sum is below THRESHOLD and fits in acc.
      step_q    <= '0;
      acc       <= sum[ACC_W-1:0];
      idle_cnt  <= (sum != '0) ? idle_cnt + CNT_W'(1) : '0;
      pending_q <= (sum != '0);
      state     <= (sum != '0) ? ACCUM : IDLE;
    end
  end

  assign bus.step        = step_q;
  assign bus.pending     = pending_q;
  assign bus.total_steps = total_q;
endmodule

// File: tb/tb_difftest_step_batcher.sv
// Bench for difftest_step_batcher: two instances (THRESHOLD 64/TIMEOUT 16 and
// THRESHOLD 255/TIMEOUT 32) share one stimulus stream; each is compared every
// cycle against a behavioural model, with literal spot checks on top.
module tb_difftest_step_batcher;
  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       v_in  = 1'b0;
  logic [3:0] n_in  = '0;
  logic       fr_in = 1'b0;
  logic       sr_in = 1'b0;
  bit         cmp_on = 1'b0;
  int         n_cmp = 0;
  int         n_bad = 0;
  longint     accepted;

  always #5 clock = ~clock;

  difftest_step_batcher_if #(.STEP_WIDTH(8), .IN_WIDTH(4)) bus_a ();
  difftest_step_batcher_if #(.STEP_WIDTH(8), .IN_WIDTH(4)) bus_b ();

  assign bus_a.in_valid    = v_in;
  assign bus_a.in_steps    = n_in;
  assign bus_a.flush_req   = fr_in;
  assign bus_a.simv_result = sr_in;
  assign bus_b.in_valid    = v_in;
  assign bus_b.in_steps    = n_in;
  assign bus_b.flush_req   = fr_in;
  assign bus_b.simv_result = sr_in;

  difftest_step_batcher #(.STEP_WIDTH(8), .IN_WIDTH(4), .THRESHOLD(64), .TIMEOUT(16))
    dut_a (.clock(clock), .reset(reset), .bus(bus_a));
  difftest_step_batcher #(.STEP_WIDTH(8), .IN_WIDTH(4), .THRESHOLD(255), .TIMEOUT(32))
    dut_b (.clock(clock), .reset(reset), .bus(bus_b));

  typedef struct {
    int     acc;
    int     quiet;
    bit     halt;
    longint total;
    int     step;
    bit     pending;
  } mst_t;

  mst_t ma, mb;

  function automatic mst_t mstep(mst_t s, int thr, int to, bit rst, bit v, int n,
                                 bit fr, bit sr);
    mst_t r;
    int   sum;
    r = s;
    if (rst) begin
      r.acc = 0; r.quiet = 0; r.halt = 0; r.total = 0; r.step = 0; r.pending = 0;
      return r;
    end
    if (s.halt || sr) begin
      r.halt = 1; r.acc = 0; r.quiet = 0; r.step = 0; r.pending = 0;
      return r;
    end
    sum = s.acc + (v ? n : 0);
    if (sum >= thr || (fr && sum != 0) || (s.acc != 0 && s.quiet == to - 1)) begin
      r.step  = (sum > 255) ? 255 : sum;
      r.acc   = sum - r.step;
      r.quiet = 0;
      r.total = s.total + r.step;
    end else begin
      r.step  = 0;
      r.acc   = sum;
      r.quiet = (sum != 0) ? s.quiet + 1 : 0;
    end
    r.pending = (r.acc != 0);
    return r;
  endfunction

  always @(posedge clock) begin
    ma = mstep(ma, 64, 16, reset, v_in, int'(n_in), fr_in, sr_in);
    mb = mstep(mb, 255, 32, reset, v_in, int'(n_in), fr_in, sr_in);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  always @(negedge clock) begin
    if (cmp_on) begin
      chk("a_step",    64'(bus_a.step),    64'(ma.step));
      chk("a_pending", 64'(bus_a.pending), 64'(ma.pending));
      chk("a_total",   bus_a.total_steps,  ma.total);
      chk("b_step",    64'(bus_b.step),    64'(mb.step));
      chk("b_pending", 64'(bus_b.pending), 64'(mb.pending));
      chk("b_total",   bus_b.total_steps,  mb.total);
    end
  end

  // Inputs change on the falling edge; returns at the next falling edge, when
  // the outputs reflect the cycle just applied.
  task automatic apply(input bit v, input int n, input bit fr = 0, input bit sr = 0,
                       input bit rst = 0);
    v_in  = v;
    n_in  = 4'(n);
    fr_in = fr;
    sr_in = sr;
    reset = rst;
    @(negedge clock);
  endtask

  task automatic do_reset();
    apply(0, 0, 0, 0, 1);
    apply(0, 0, 0, 0, 1);
    apply(0, 0);
  endtask

  initial begin
    ma = '{default: 0};
    mb = '{default: 0};
    @(negedge clock);
    apply(0, 0, 0, 0, 1);
    cmp_on = 1'b1;
    apply(0, 0, 0, 0, 1);
    chk("rst_step",    64'(bus_a.step), 64'd0);
    chk("rst_pending", 64'(bus_a.pending), 64'd0);
    chk("rst_total",   bus_a.total_steps, 64'd0);

    // threshold flush: 8 x 8 = 64
    for (int i = 0; i < 7; i++) begin
      apply(1, 8);
      chk("thr_quiet", 64'(bus_a.step), 64'd0);
    end
    apply(1, 8);
    chk("thr_step",    64'(bus_a.step), 64'd64);
    chk("thr_pending", 64'(bus_a.pending), 64'd0);
    chk("thr_total",   bus_a.total_steps, 64'd64);

    // idle timeout: 3 emitted 16 cycles after the input
    do_reset();
    apply(1, 3);
    for (int i = 0; i < 14; i++) begin
      apply(0, 0);
      chk("to_wait", 64'(bus_a.step), 64'd0);
    end
    apply(0, 0);
    chk("to_step", 64'(bus_a.step), 64'd3);
    apply(0, 0);
    chk("to_after", 64'(bus_a.step), 64'd0);

    // explicit flush, then flush_req on an empty accumulator
    apply(1, 5);
    apply(1, 2, 1);
    chk("fr_step", 64'(bus_a.step), 64'd7);
    apply(0, 0, 1);
    chk("fr_empty", 64'(bus_a.step), 64'd0);

    // saturation on the 255-threshold instance: 250 + 15 -> 255 + remainder 10
    do_reset();
    for (int i = 0; i < 16; i++) apply(1, 15);
    apply(1, 10);
    chk("sat_pre", 64'(bus_b.step), 64'd0);
    apply(1, 15);
    chk("sat_step",    64'(bus_b.step), 64'd255);
    chk("sat_pending", 64'(bus_b.pending), 64'd1);
    for (int i = 0; i < 31; i++) begin
      apply(0, 0);
      chk("sat_hold", 64'(bus_b.step), 64'd0);
    end
    apply(0, 0);
    chk("sat_rem",   64'(bus_b.step), 64'd10);
    chk("sat_total", bus_b.total_steps, 64'd265);

    // halt with a flush-worthy input in the same cycle
    do_reset();
    for (int i = 0; i < 8; i++) apply(1, 8);
    apply(1, 15);
    apply(1, 15);
    apply(1, 10);
    apply(1, 15, 1, 1);
    chk("halt_step",    64'(bus_a.step), 64'd0);
    chk("halt_pending", 64'(bus_a.pending), 64'd0);
    for (int i = 0; i < 100; i++) begin
      apply(1, int'($urandom_range(15)), 1'($urandom_range(1)), 1'($urandom_range(1)));
      chk("halt_quiet", 64'(bus_a.step), 64'd0);
    end
    chk("halt_total", bus_a.total_steps, 64'd64);
    do_reset();
    chk("halt_rst_total", bus_a.total_steps, 64'd0);
    apply(1, 5);
    chk("halt_resume", 64'(bus_a.pending), 64'd1);

    // reset mid-accumulation discards the count
    do_reset();
    apply(1, 15);
    apply(1, 15);
    chk("mid_pending", 64'(bus_a.pending), 64'd1);
    apply(1, 7, 0, 0, 1);
    chk("mid_step",    64'(bus_a.step), 64'd0);
    chk("mid_pending0", 64'(bus_a.pending), 64'd0);
    for (int i = 0; i < 20; i++) apply(0, 0);
    chk("mid_total", bus_a.total_steps, 64'd0);

    // random soak, then drain everything by timeout
    do_reset();
    accepted = 0;
    for (int i = 0; i < 2000; i++) begin
      automatic bit v  = 1'($urandom_range(3) != 0);
      automatic int n  = int'($urandom_range(15));
      automatic bit fr = 1'($urandom_range(15) == 0);
      if (v) accepted += n;
      apply(v, n, fr);
    end
    for (int i = 0; i < 80; i++) apply(0, 0);
    chk("soak_a_total", bus_a.total_steps, 64'(accepted));
    chk("soak_b_total", bus_b.total_steps, 64'(accepted));
    chk("soak_a_idle",  64'(bus_a.pending), 64'd0);
    chk("soak_b_idle",  64'(bus_b.pending), 64'd0);

    cmp_on = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
